// File: rtl/dct_pkg.sv
// ============================================================================
// Module      : dct_pkg
// Description : Shared constants and types for the 2D-DCT transpose buffer.
//               BLOCK_DIM/BLOCK_SIZE describe the 8x8 block geometry and
//               bank_state_t is the per-bank occupancy state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dct_pkg;

  localparam int BLOCK_DIM  = 8;
  localparam int BLOCK_SIZE = 64;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Flat storage address of coefficient (row, col) in a row-major block.
  function automatic logic [5:0] coef_addr(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dct_transpose_bank.sv
// ============================================================================
// Module      : dct_transpose_bank
// Description : One 8x8 coefficient bank of the ping-pong transpose buffer.
//               Holds the coefficients, the bank occupancy state and the
//               sof/eol sideband flags captured while the block was written.
// Ports       : clk_i/rst_i      - clock, synchronous active-high reset
//               wr_*             - write port (row, col, data, sideband)
//               rd_en_i/rd_last_i- column handshake / last column of block
//               rd_col_i         - column being presented
//               state_o, sof_o, eol_o, col_data_o - bank status and column
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_transpose_bank
  import dct_pkg::*;
#(
  parameter int COEF_WIDTH = 11
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_en_i,
  input  logic [2:0]                      wr_row_i,
  input  logic [2:0]                      wr_col_i,
  input  logic [COEF_WIDTH-1:0]           wr_data_i,
  input  logic                            wr_first_i,
  input  logic                            wr_last_i,
  input  logic                            wr_sof_i,
  input  logic                            wr_eol_i,
  input  logic                            rd_en_i,
  input  logic                            rd_last_i,
  input  logic [2:0]                      rd_col_i,
  output bank_state_t                     state_o,
  output logic                            sof_o,
  output logic                            eol_o,
  output logic [BLOCK_DIM*COEF_WIDTH-1:0] col_data_o
);

  // Storage is deliberately left unreset; state gates any stale contents.
  logic [COEF_WIDTH-1:0] r_mem [BLOCK_SIZE];
  bank_state_t           r_state;
  logic                  r_sof;
  logic                  r_eol;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[coef_addr(wr_row_i, wr_col_i)] <= wr_data_i;
    end
  end

  // Writes only happen while EMPTY/FILLING and reads only while
  // FULL/DRAINING, so the two enables are never active together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= BANK_EMPTY;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
    end else if (wr_en_i) begin
      r_state <= wr_last_i ? BANK_FULL : BANK_FILLING;
      if (wr_first_i) begin
        r_sof <= wr_sof_i;
      end
      r_eol <= r_eol | wr_eol_i;
    end else if (rd_en_i) begin
      if (rd_last_i) begin
        r_state <= BANK_EMPTY;
        r_sof   <= 1'b0;
        r_eol   <= 1'b0;
      end else begin
        r_state <= BANK_DRAINING;
      end
    end
  end

  assign state_o = r_state;
  assign sof_o   = r_sof;
  assign eol_o   = r_eol;

  // Lane r of the column read port carries block row r.
  for (genvar r = 0; r < BLOCK_DIM; r++) begin : g_lane
    assign col_data_o[r*COEF_WIDTH +: COEF_WIDTH] = r_mem[coef_addr(3'(r), rd_col_i)];
  end

endmodule

`default_nettype wire

// File: rtl/dct_transpose_ctrl.sv
// ============================================================================
// Module      : dct_transpose_ctrl
// Description : Ping-pong transpose-buffer controller between the row-pass
//               and column-pass 1D-DCT engines. Scalar coefficients arrive
//               row-major per 8x8 block; each full block is replayed as
//               eight 8-lane column vectors.
// Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//               coef_t*_i/coef_tready_o - AXI4-Stream slave, one coefficient
//                                         per beat (tdata zero-padded)
//               col_t*_o/col_tready_i   - AXI4-Stream master, one column per
//                                         beat, lane r = block row r
// Config      : DCT_TRANSPOSE_OUT_REG_EN - adds a registered col output stage
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_transpose_ctrl
  import dct_pkg::*;
#(
  parameter int COEF_WIDTH = 11
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [((COEF_WIDTH+7)/8)*8-1:0]        coef_tdata_i,
  input  logic                                   coef_tvalid_i,
  output logic                                   coef_tready_o,
  input  logic                                   coef_tuser_i,
  input  logic                                   coef_tlast_i,
  output logic [BLOCK_DIM*COEF_WIDTH-1:0]        col_tdata_o,
  output logic                                   col_tvalid_o,
  input  logic                                   col_tready_i,
  output logic                                   col_tuser_o,
  output logic                                   col_tlast_o,
  output logic [(BLOCK_DIM*COEF_WIDTH+7)/8-1:0]  col_tkeep_o,
  output logic [(BLOCK_DIM*COEF_WIDTH+7)/8-1:0]  col_tstrb_o
);

  localparam int c_in_width  = ((COEF_WIDTH+7)/8)*8;
  localparam int c_col_width = BLOCK_DIM*COEF_WIDTH;

  logic [5:0]             r_wr_cnt;
  logic                   r_wr_bank;
  logic [2:0]             r_rd_col;
  logic                   r_rd_bank;

  bank_state_t            w_bank_state [2];
  logic                   w_bank_sof   [2];
  logic                   w_bank_eol   [2];
  logic [c_col_width-1:0] w_bank_col   [2];

  bank_state_t            w_wr_state;
  bank_state_t            w_rd_state;
  logic                   w_wr_fire;
  logic                   w_rd_fire;
  logic                   w_rd_last;
  logic                   w_mux_valid;
  logic                   w_mux_ready;
  logic [c_col_width-1:0] w_mux_data;
  logic                   w_mux_user;
  logic                   w_mux_last;

  if (c_in_width > COEF_WIDTH) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^coef_tdata_i[c_in_width-1:COEF_WIDTH];
  end else begin : g_nopad
  end

  // ---------------- write side ----------------
  assign w_wr_state    = w_bank_state[r_wr_bank];
  assign coef_tready_o = (w_wr_state == BANK_EMPTY) || (w_wr_state == BANK_FILLING);
  assign w_wr_fire     = coef_tvalid_i && coef_tready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_cnt  <= 6'd0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_fire) begin
      r_wr_cnt <= r_wr_cnt + 6'd1;
      if (r_wr_cnt == 6'd63) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // ---------------- read side ----------------
  assign w_rd_state  = w_bank_state[r_rd_bank];
  assign w_mux_valid = (w_rd_state == BANK_FULL) || (w_rd_state == BANK_DRAINING);
  assign w_rd_last   = (r_rd_col == 3'd7);
  assign w_rd_fire   = w_mux_valid && w_mux_ready;
  assign w_mux_data  = w_mux_valid ? w_bank_col[r_rd_bank] : '0;
  assign w_mux_user  = w_mux_valid && w_bank_sof[r_rd_bank] && (r_rd_col == 3'd0);
  assign w_mux_last  = w_mux_valid && w_bank_eol[r_rd_bank] && w_rd_last;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_col  <= 3'd0;
      r_rd_bank <= 1'b0;
    end else if (w_rd_fire) begin
      r_rd_col <= r_rd_col + 3'd1;
      if (w_rd_last) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // ---------------- banks ----------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_transpose_bank #(
      .COEF_WIDTH (COEF_WIDTH)
    ) u_bank (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (w_wr_fire && (r_wr_bank == 1'(b))),
      .wr_row_i   (r_wr_cnt[5:3]),
      .wr_col_i   (r_wr_cnt[2:0]),
      .wr_data_i  (coef_tdata_i[COEF_WIDTH-1:0]),
      .wr_first_i (r_wr_cnt == 6'd0),
      .wr_last_i  (r_wr_cnt == 6'd63),
      .wr_sof_i   (coef_tuser_i),
      .wr_eol_i   (coef_tlast_i),
      .rd_en_i    (w_rd_fire && (r_rd_bank == 1'(b))),
      .rd_last_i  (w_rd_last),
      .rd_col_i   (r_rd_col),
      .state_o    (w_bank_state[b]),
      .sof_o      (w_bank_sof[b]),
      .eol_o      (w_bank_eol[b]),
      .col_data_o (w_bank_col[b])
    );
  end

  // ---------------- output stage ----------------
`ifdef DCT_TRANSPOSE_OUT_REG_EN
  logic                   r_out_valid;
  logic [c_col_width-1:0] r_out_data;
  logic                   r_out_user;
  logic                   r_out_last;

  // Refill whenever the register is empty or being consumed; the mux side
  // is already zeroed when invalid, so the register inherits that.
  assign w_mux_ready = !r_out_valid || col_tready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_user  <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_mux_ready) begin
      r_out_valid <= w_mux_valid;
      r_out_data  <= w_mux_data;
      r_out_user  <= w_mux_user;
      r_out_last  <= w_mux_last;
    end
  end

  assign col_tvalid_o = r_out_valid;
  assign col_tdata_o  = r_out_data;
  assign col_tuser_o  = r_out_user;
  assign col_tlast_o  = r_out_last;
`else
  assign w_mux_ready  = col_tready_i;
  assign col_tvalid_o = w_mux_valid;
  assign col_tdata_o  = w_mux_data;
  assign col_tuser_o  = w_mux_user;
  assign col_tlast_o  = w_mux_last;
`endif

  assign col_tkeep_o = '1;
  assign col_tstrb_o = '1;

endmodule

`default_nettype wire
